// File: rtl/snake_controller_if.sv
// Bundles the button, datapath-handshake, frame and LED-matrix signals of the snake controller.
interface snake_controller_if;
  logic [3:0]  direction_in;
  logic [1:0]  from_logic;
  logic [0:63] led_array_flat;
  logic [1:0]  game_state;
  logic [1:0]  direction_state;
  logic [1:0]  execution_state;
  logic [1:0]  to_logic;
  logic [7:0]  row_cathode;
  logic [7:0]  column_anode;

  // Environment side: drives buttons, datapath status and frame.
  modport master (
    output direction_in, from_logic, led_array_flat,
    input  game_state, direction_state, execution_state, to_logic,
           row_cathode, column_anode
  );

  // Controller side.
  modport slave (
    input  direction_in, from_logic, led_array_flat,
    output game_state, direction_state, execution_state, to_logic,
           row_cathode, column_anode
  );
endinterface

// File: rtl/snake_controller.sv
// Top-level control for the 8x8 LED snake game: game, direction and execution FSMs
// plus row-multiplexed LED matrix drive. Every output comes straight from a register.
module snake_controller #(
  parameter int unsigned ROW_REPEAT = 2
) (
  input  logic              clka,
  input  logic              restart_n,
  snake_controller_if.slave bus
);

  localparam int unsigned DISP_LEN = 8 * ROW_REPEAT;
  localparam int unsigned CNT_W    = $clog2(DISP_LEN);

  typedef enum logic [1:0] {
    GAME_IDLE = 2'b00,
    GAME_PLAY = 2'b01,
    GAME_OVER = 2'b10
  } game_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    EXEC_CHECK   = 2'b00,
    EXEC_INPUT   = 2'b01,
    EXEC_DISPLAY = 2'b10
  } exec_e;

  game_e            game_q,  game_d;
  dir_e             dir_q,   dir_d;
  exec_e            exec_q,  exec_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       to_logic_q, to_logic_d;
  logic [7:0]       row_q,   row_d;
  logic [7:0]       col_q,   col_d;

  dir_e             btn_dir;
  logic             btn_any;
  logic [2:0]       row_idx;

  // Button decode with priority up > down > left > right.
  always_comb begin
    btn_any = |bus.direction_in;
    btn_dir = DIR_RIGHT;
    if (bus.direction_in[0])      btn_dir = DIR_UP;
    else if (bus.direction_in[1]) btn_dir = DIR_DOWN;
    else if (bus.direction_in[2]) btn_dir = DIR_LEFT;
  end

  // Next-state logic for all three FSMs and the registered matrix/handshake outputs.
  always_comb begin
    game_d     = game_q;
    dir_d      = dir_q;
    exec_d     = exec_q;
    cnt_d      = cnt_q;
    to_logic_d = 2'b00;
    row_d      = 8'hFF;
    col_d      = 8'h00;
    row_idx    = 3'd0;

    // Opposite directions differ only in bit 0, so a reversal is dir ^ 1.
    if (game_q != GAME_OVER && btn_any) begin
      if (game_q == GAME_IDLE || (2'(btn_dir) != (2'(dir_q) ^ 2'b01))) begin
        dir_d = btn_dir;
      end
    end

    case (game_q)
      GAME_IDLE: if (btn_any) game_d = GAME_PLAY;
      GAME_PLAY: if (exec_q == EXEC_INPUT && bus.from_logic == 2'b11) game_d = GAME_OVER;
      GAME_OVER: game_d = GAME_OVER;
      default:   game_d = GAME_IDLE;
    endcase

    case (exec_q)
      EXEC_CHECK: begin
        exec_d = (game_q == GAME_IDLE) ? EXEC_DISPLAY : EXEC_INPUT;
        cnt_d  = '0;
      end
      EXEC_INPUT: begin
        // While playing, wait indefinitely for the datapath to finish a step.
        if (game_q != GAME_PLAY || bus.from_logic[0]) begin
          exec_d = EXEC_DISPLAY;
          cnt_d  = '0;
        end
      end
      EXEC_DISPLAY: begin
        if (cnt_q == CNT_W'(DISP_LEN - 1)) begin
          exec_d = EXEC_CHECK;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        exec_d = EXEC_CHECK;
        cnt_d  = '0;
      end
    endcase

    // Outputs follow the next state so they line up with the state registers.
    if (exec_d == EXEC_INPUT && game_d == GAME_PLAY) to_logic_d = 2'b01;

    if (exec_d == EXEC_DISPLAY) begin
      row_idx = 3'(cnt_d / CNT_W'(ROW_REPEAT));
      row_d   = ~(8'b1 << row_idx);
      col_d   = bus.led_array_flat[{row_idx, 3'b000} +: 8];
    end
  end

  // State and output registers.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      game_q     <= GAME_IDLE;
      dir_q      <= DIR_UP;
      exec_q     <= EXEC_CHECK;
      cnt_q      <= '0;
      to_logic_q <= 2'b00;
      row_q      <= 8'hFF;
      col_q      <= 8'h00;
    end else begin
      game_q     <= game_d;
      dir_q      <= dir_d;
      exec_q     <= exec_d;
      cnt_q      <= cnt_d;
      to_logic_q <= to_logic_d;
      row_q      <= row_d;
      col_q      <= col_d;
    end
  end

  assign bus.game_state      = game_q;
  assign bus.direction_state = dir_q;
  assign bus.execution_state = exec_q;
  assign bus.to_logic        = to_logic_q;
  assign bus.row_cathode     = row_q;
  assign bus.column_anode    = col_q;

endmodule

// File: tb/tb_snake_controller.sv
// Self-checking bench for snake_controller: expected outputs are queued as stimulus
// is applied and compared after each active clock edge.
module tb_snake_controller;

  logic clka;
  logic restart_n;
  snake_controller_if bus ();

  snake_controller #(.ROW_REPEAT(2)) dut (
    .clka      (clka),
    .restart_n (restart_n),
    .bus       (bus)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  typedef struct {
    logic [1:0] game;
    logic [1:0] dir;
    logic [1:0] exec;
    logic [1:0] tl;
    logic [7:0] row;
    logic [7:0] col;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] frame_rows [8];

  function automatic logic [0:63] build_frame();
    logic [0:63] f;
    for (int r = 0; r < 8; r++) f[8*r +: 8] = frame_rows[r];
    return f;
  endfunction

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  // Advance until the controller reaches CHECK, bounded.
  task automatic wait_for_check(input int budget);
    int n;
    n = 0;
    while (bus.execution_state !== 2'b00 && n < budget) begin
      step();
      n++;
    end
    n_checks++;
    if (bus.execution_state !== 2'b00) begin
      n_fail++;
      $display("FAIL wait_check: exec=%b required 00 within %0d cycles", bus.execution_state, budget);
    end
  endtask

  // Queue a full DISPLAY pass followed by the return to CHECK.
  task automatic push_display_pass(input logic [1:0] game, input logic [1:0] dir);
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      e.game = game; e.dir = dir; e.exec = 2'b10; e.tl = 2'b00;
      e.row  = ~(8'b1 << (k / 2));
      e.col  = frame_rows[k / 2];
      sb.push_back(e);
    end
    e.game = game; e.dir = dir; e.exec = 2'b00; e.tl = 2'b00; e.row = 8'hFF; e.col = 8'h00;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    n_checks += 6;
    if (bus.game_state !== 2'b00) begin n_fail++; $display("FAIL reset_game: got %b want 00", bus.game_state); end
    if (bus.direction_state !== 2'b00) begin n_fail++; $display("FAIL reset_dir: got %b want 00", bus.direction_state); end
    if (bus.execution_state !== 2'b00) begin n_fail++; $display("FAIL reset_exec: got %b want 00", bus.execution_state); end
    if (bus.to_logic !== 2'b00) begin n_fail++; $display("FAIL reset_to_logic: got %b want 00", bus.to_logic); end
    if (bus.row_cathode !== 8'hFF) begin n_fail++; $display("FAIL reset_row: got %h want FF", bus.row_cathode); end
    if (bus.column_anode !== 8'h00) begin n_fail++; $display("FAIL reset_col: got %h want 00", bus.column_anode); end
  endtask

  task automatic test_idle_display();
    exp_t e;
    push_display_pass(2'b00, 2'b00);
    for (int k = 0; k < 17; k++) begin
      step();
      e = sb.pop_front();
      n_checks += 4;
      if (bus.execution_state !== e.exec) begin n_fail++; $display("FAIL idle_exec[%0d]: got %b want %b", k, bus.execution_state, e.exec); end
      if (bus.row_cathode !== e.row) begin n_fail++; $display("FAIL idle_row[%0d]: got %b want %b", k, bus.row_cathode, e.row); end
      if (bus.column_anode !== e.col) begin n_fail++; $display("FAIL idle_col[%0d]: got %b want %b", k, bus.column_anode, e.col); end
      if (bus.to_logic !== e.tl) begin n_fail++; $display("FAIL idle_tl[%0d]: got %b want %b", k, bus.to_logic, e.tl); end
    end
  endtask

  task automatic test_start();
    bus.direction_in = 4'b0001;
    step();
    bus.direction_in = 4'b0000;
    n_checks += 3;
    if (bus.game_state !== 2'b01) begin n_fail++; $display("FAIL start_game: got %b want 01", bus.game_state); end
    if (bus.direction_state !== 2'b00) begin n_fail++; $display("FAIL start_dir: got %b want 00", bus.direction_state); end
    if (bus.execution_state !== 2'b10) begin n_fail++; $display("FAIL start_exec: got %b want 10", bus.execution_state); end
    wait_for_check(40);
    for (int k = 0; k < 7; k++) begin
      step();
      n_checks += 2;
      if (bus.execution_state !== 2'b01) begin n_fail++; $display("FAIL wait_exec[%0d]: got %b want 01", k, bus.execution_state); end
      if (bus.to_logic !== 2'b01) begin n_fail++; $display("FAIL wait_tl[%0d]: got %b want 01", k, bus.to_logic); end
    end
  endtask

  task automatic test_step_done();
    exp_t e;
    for (int r = 0; r < 8; r++) frame_rows[r] = 8'h00;
    frame_rows[2] = 8'b00100000;
    frame_rows[3] = 8'b00000100;
    bus.led_array_flat = build_frame();
    bus.from_logic = 2'b01;
    push_display_pass(2'b01, 2'b00);
    e.game = 2'b01; e.dir = 2'b00; e.exec = 2'b01; e.tl = 2'b01; e.row = 8'hFF; e.col = 8'h00;
    sb.push_back(e);
    for (int k = 0; k < 18; k++) begin
      step();
      bus.from_logic = 2'b00;
      e = sb.pop_front();
      n_checks += 5;
      if (bus.game_state !== e.game) begin n_fail++; $display("FAIL step_game[%0d]: got %b want %b", k, bus.game_state, e.game); end
      if (bus.execution_state !== e.exec) begin n_fail++; $display("FAIL step_exec[%0d]: got %b want %b", k, bus.execution_state, e.exec); end
      if (bus.row_cathode !== e.row) begin n_fail++; $display("FAIL step_row[%0d]: got %b want %b", k, bus.row_cathode, e.row); end
      if (bus.column_anode !== e.col) begin n_fail++; $display("FAIL step_col[%0d]: got %b want %b", k, bus.column_anode, e.col); end
      if (bus.to_logic !== e.tl) begin n_fail++; $display("FAIL step_tl[%0d]: got %b want %b", k, bus.to_logic, e.tl); end
    end
  endtask

  task automatic test_reversal();
    logic [3:0] btn  [10] = '{4'b0010, 4'b0100, 4'b1100, 4'b1000, 4'b1001,
                              4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [1:0] want [10] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b00,
                              2'b00, 2'b11, 2'b11, 2'b01, 2'b01};
    exp_t e;
    for (int k = 0; k < 10; k++) begin
      bus.direction_in = btn[k];
      e.game = 2'b01; e.dir = want[k]; e.exec = 2'b01; e.tl = 2'b01; e.row = 8'hFF; e.col = 8'h00;
      sb.push_back(e);
      step();
      e = sb.pop_front();
      n_checks += 3;
      if (bus.direction_state !== e.dir) begin n_fail++; $display("FAIL dir[%0d] btn=%b: got %b want %b", k, btn[k], bus.direction_state, e.dir); end
      if (bus.execution_state !== e.exec) begin n_fail++; $display("FAIL dir_exec[%0d]: got %b want %b", k, bus.execution_state, e.exec); end
      if (bus.to_logic !== e.tl) begin n_fail++; $display("FAIL dir_tl[%0d]: got %b want %b", k, bus.to_logic, e.tl); end
    end
    bus.direction_in = 4'b0000;
  endtask

  task automatic test_game_over();
    bus.from_logic = 2'b11;
    step();
    bus.from_logic = 2'b00;
    bus.direction_in = 4'b0100;
    n_checks += 3;
    if (bus.game_state !== 2'b10) begin n_fail++; $display("FAIL over_game: got %b want 10", bus.game_state); end
    if (bus.execution_state !== 2'b10) begin n_fail++; $display("FAIL over_exec: got %b want 10", bus.execution_state); end
    if (bus.to_logic !== 2'b00) begin n_fail++; $display("FAIL over_tl: got %b want 00", bus.to_logic); end
    wait_for_check(40);
    step();
    n_checks += 4;
    if (bus.execution_state !== 2'b01) begin n_fail++; $display("FAIL over_input_exec: got %b want 01", bus.execution_state); end
    if (bus.to_logic !== 2'b00) begin n_fail++; $display("FAIL over_input_tl: got %b want 00", bus.to_logic); end
    if (bus.game_state !== 2'b10) begin n_fail++; $display("FAIL over_hold_game: got %b want 10", bus.game_state); end
    if (bus.direction_state !== 2'b01) begin n_fail++; $display("FAIL over_frozen_dir: got %b want 01", bus.direction_state); end
    step();
    n_checks += 3;
    if (bus.execution_state !== 2'b10) begin n_fail++; $display("FAIL over_display_exec: got %b want 10", bus.execution_state); end
    if (bus.row_cathode !== 8'hFE) begin n_fail++; $display("FAIL over_display_row: got %b want 11111110", bus.row_cathode); end
    if (bus.direction_state !== 2'b01) begin n_fail++; $display("FAIL over_frozen_dir2: got %b want 01", bus.direction_state); end
    bus.direction_in = 4'b0000;
  endtask

  task automatic test_reset_mid_display();
    step();
    step();
    step();
    #3;
    restart_n = 1'b0;
    #1;
    test_reset();
    @(posedge clka);
    #1;
    restart_n = 1'b1;
    test_reset();
    step();
    n_checks += 3;
    if (bus.game_state !== 2'b00) begin n_fail++; $display("FAIL resume_game: got %b want 00", bus.game_state); end
    if (bus.execution_state !== 2'b10) begin n_fail++; $display("FAIL resume_exec: got %b want 10", bus.execution_state); end
    if (bus.row_cathode !== 8'hFE) begin n_fail++; $display("FAIL resume_row: got %b want 11111110", bus.row_cathode); end
  endtask

  initial begin
    restart_n = 1'b0;
    bus.direction_in = 4'b0000;
    bus.from_logic = 2'b00;
    for (int r = 0; r < 8; r++) frame_rows[r] = 8'(8'h11 * (r + 1));
    frame_rows[3] = 8'b00100100;
    bus.led_array_flat = build_frame();
    #12;
    test_reset();
    @(posedge clka);
    #1;
    restart_n = 1'b1;
    test_idle_display();
    test_start();
    test_step_done();
    test_reversal();
    test_game_over();
    test_reset_mid_display();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
